// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - command FIFO and micro-step sequencer driving the opermux ALU
// Binary: LDB, SWAP, LDA, EXEC; unary: LDA, EXEC; raw: one step. Each step is SETUP then STROBE.
module alu_sequencer #(
   parameter int DEPTH   = 4,
   parameter int ALU_LAT = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [3:0] cmd_op,
   input  logic [7:0] cmd_a,
   input  logic [7:0] cmd_b,
   output logic [3:0] alu_sel,
   output logic [7:0] alu_data,
   output logic       alu_en,
   input  logic [7:0] alu_y,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [7:0] res_data,
   output logic [3:0] res_op,
   output logic       busy,
   output logic [7:0] done_cnt
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
   localparam logic [LW-1:0] LAT_LAST = LW'(ALU_LAT - 1);
   localparam logic [1:0]    CL_BIN = 2'd0, CL_UN = 2'd1, CL_RAW = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE, S_LDB, S_SWAP, S_LDA, S_EXEC, S_WAIT, S_HOLD, S_RAW
   } state_t;

   function automatic logic [1:0] op_class(input logic [3:0] op);
      case (op)
         4'h2, 4'h3, 4'hB, 4'hC: op_class = CL_UN;
         4'hD, 4'hE, 4'hF:       op_class = CL_RAW;
         default:                op_class = CL_BIN;
      endcase
   endfunction

   logic [19:0]   fifo_mem [DEPTH];
   logic [AW:0]   wr_ptr_q, rd_ptr_q;
   logic [AW:0]   fill;
   logic          full, empty, push, pop;
   logic [19:0]   head;

   state_t        state_q, state_d;
   logic          phase_q, phase_d;
   logic [LW-1:0] wait_q, wait_d;
   logic [3:0]    op_q, op_d;
   logic [7:0]    a_q, a_d, b_q, b_d;
   logic [3:0]    sel_q, sel_d;
   logic [7:0]    data_q, data_d;
   logic          en_q, en_d;
   logic          res_valid_q, res_valid_d;
   logic [7:0]    res_data_q, res_data_d;
   logic [3:0]    res_op_q, res_op_d;
   logic [7:0]    done_q, done_d;

   assign fill  = wr_ptr_q - rd_ptr_q;
   assign full  = (fill == FULL_CNT);
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign push  = cmd_valid && !full;
   assign head  = fifo_mem[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= {cmd_op, cmd_a, cmd_b};
   end

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      wait_d      = wait_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      sel_d       = sel_q;
      data_d      = data_q;
      en_d        = 1'b0;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_op_d    = res_op_q;
      done_d      = done_q;
      pop         = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!empty) begin
               pop              = 1'b1;
               {op_d, a_d, b_d} = head;
               phase_d          = 1'b0;
               case (op_class(head[19:16]))
                  CL_BIN: begin
                     state_d = S_LDB;
                     sel_d   = 4'hF;
                     data_d  = head[7:0];
                  end
                  CL_UN: begin
                     state_d = S_LDA;
                     sel_d   = 4'hF;
                     data_d  = head[15:8];
                  end
                  default: begin
                     state_d = S_RAW;
                     sel_d   = head[19:16];
                     data_d  = head[15:8];
                  end
               endcase
            end
         end
         S_LDB, S_SWAP, S_LDA, S_EXEC, S_RAW: begin
            if (!phase_q) begin
               phase_d = 1'b1;
               en_d    = 1'b1;
            end else begin
               // Leaving a step: the next step's SETUP values are loaded here.
               phase_d = 1'b0;
               case (state_q)
                  S_LDB: begin
                     state_d = S_SWAP;
                     sel_d   = 4'hE;
                     data_d  = 8'h00;
                  end
                  S_SWAP: begin
                     state_d = S_LDA;
                     sel_d   = 4'hF;
                     data_d  = a_q;
                  end
                  S_LDA: begin
                     state_d = S_EXEC;
                     sel_d   = op_q;
                     data_d  = 8'h00;
                  end
                  S_EXEC: begin
                     state_d = S_WAIT;
                     wait_d  = '0;
                  end
                  default: state_d = S_IDLE;
               endcase
            end
         end
         S_WAIT: begin
            if (wait_q == LAT_LAST) begin
               res_valid_d = 1'b1;
               res_data_d  = alu_y;
               res_op_d    = op_q;
               done_d      = done_q + 8'd1;
               state_d     = S_HOLD;
            end else begin
               wait_d = wait_q + LW'(1);
            end
         end
         S_HOLD: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         state_q     <= S_IDLE;
         phase_q     <= 1'b0;
         wait_q      <= '0;
         op_q        <= 4'h0;
         a_q         <= 8'h00;
         b_q         <= 8'h00;
         sel_q       <= 4'h0;
         data_q      <= 8'h00;
         en_q        <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= 8'h00;
         res_op_q    <= 4'h0;
         done_q      <= 8'h00;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         state_q     <= state_d;
         phase_q     <= phase_d;
         wait_q      <= wait_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sel_q       <= sel_d;
         data_q      <= data_d;
         en_q        <= en_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_op_q    <= res_op_d;
         done_q      <= done_d;
      end
   end

   assign cmd_ready = !full;
   assign alu_sel   = sel_q;
   assign alu_data  = data_q;
   assign alu_en    = en_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_op    = res_op_q;
   assign done_cnt  = done_q;
   assign busy      = !empty || (state_q != S_IDLE);

endmodule
